// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control bundle between the multicycle main control FSM and the datapath
//
// Ports carried:
//   opcode, mem_ready, zero : datapath -> control (IR opcode, memory handshake, ALU zero flag)
//   IorD .. RegWrite        : control -> datapath mux selects and write enables
//   mem_err, illegal_op     : one-cycle error pulses
//   state                   : current FSM state, for debug
// Modports: master = control FSM, slave = datapath side.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteEn;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       mem_err;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready, zero,
        output IorD, MemWrite, IRWrite, PCWrite, PCWriteEn, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, MemtoReg, RegDst, RegWrite,
               mem_err, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  IorD, MemWrite, IRWrite, PCWrite, PCWriteEn, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, MemtoReg, RegDst, RegWrite,
               mem_err, illegal_op, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle main control FSM with memory-ready stall and wait timeout
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mc_control_fsm_if.master (opcode/mem_ready/zero in, datapath controls,
//           mem_err/illegal_op pulses and debug state out)
// Parameters:
//   MEM_TIMEOUT : max cycles a memory state waits for mem_ready (>= 1)
//   CNT_W       : wait counter width, 2**CNT_W > MEM_TIMEOUT
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q;
    logic             mem_wait;
    logic             timeout;

    logic       iord, mem_w, ir_w, pc_w, branch, alusrca, memtoreg, regdst, reg_w, ill;
    logic [1:0] pcsrc, alusrcb, aluop;

    // States that sit on the memory handshake and are therefore subject to the timeout.
    assign mem_wait = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);

    // mem_ready in the final allowed cycle still completes the access normally.
    assign timeout  = mem_wait && !bus.mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        mem_w    = 1'b0;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        reg_w    = 1'b0;
        ill      = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                ir_w    = bus.mem_ready;
                pc_w    = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alusrcb = 2'b10;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        ill     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                iord = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                reg_w    = 1'b1;
                state_d  = FETCH;
            end
            MEMWRITE: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst  = 1'b1;
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pc_w    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (timeout) state_d = FETCH;

        // Counter restarts on every state change, on handshake completion and on abort.
        if (timeout || bus.mem_ready || !mem_wait || (state_d != state_q))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= timeout;
        end
    end

    // Write enables are gated directly by reset so nothing is written while it is held low.
    assign bus.IRWrite    = reset & ir_w;
    assign bus.PCWrite    = reset & pc_w;
    assign bus.PCWriteEn  = reset & (pc_w | (branch & bus.zero));
    assign bus.MemWrite   = reset & mem_w;
    assign bus.RegWrite   = reset & reg_w;
    assign bus.IorD       = iord;
    assign bus.Branch     = branch;
    assign bus.PCSrc      = pcsrc;
    assign bus.ALUSrcA    = alusrca;
    assign bus.ALUSrcB    = alusrcb;
    assign bus.ALUOp      = aluop;
    assign bus.MemtoReg   = memtoreg;
    assign bus.RegDst     = regdst;
    assign bus.illegal_op = ill;
    assign bus.mem_err    = mem_err_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    localparam int TMO = 16;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    mc_control_fsm_if bus_if ();

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // {IorD, MemWrite, IRWrite, PCWrite, PCWriteEn, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp, MemtoReg, RegDst, RegWrite, illegal_op}
    logic [16:0] ctl;
    assign ctl = {bus_if.IorD, bus_if.MemWrite, bus_if.IRWrite, bus_if.PCWrite, bus_if.PCWriteEn,
                  bus_if.Branch, bus_if.PCSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUOp,
                  bus_if.MemtoReg, bus_if.RegDst, bus_if.RegWrite, bus_if.illegal_op};

    localparam logic [16:0] C_FETCH_R = 17'b0_0_1_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] C_FETCH_W = 17'b0_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_00_0_10_00_0_0_0_0;
    localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_00_0_10_00_0_0_0_1;
    localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] C_MEMREAD = 17'b1_0_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [16:0] C_ALUWB   = 17'b0_0_0_0_0_0_00_0_00_00_0_1_1_0;
    localparam logic [16:0] C_BR1     = 17'b0_0_0_0_1_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] C_BR0     = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_1_0;
    localparam logic [16:0] C_JUMP    = 17'b0_0_0_1_1_0_10_0_00_00_0_0_0_0;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic       rw;
        logic       pcwe;
        logic       err;
        logic       ill;
    } cyc_t;
    cyc_t q[$];
    logic err_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [5:0] op, input logic mr, input logic z);
        bus_if.opcode    = op;
        bus_if.mem_ready = mr;
        bus_if.zero      = z;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.zero      = 1'b0;
        bus_if.opcode    = 6'h00;
        adv();
        adv();
        reset = 1'b1;
    endtask

    task automatic addv(input logic [5:0] op, input logic mr, input logic z,
                        input logic [3:0] st, input logic [16:0] c);
        vec_t v;
        v.op = op; v.mr = mr; v.z = z; v.st = st; v.ctl = c;
        tbl.push_back(v);
    endtask

    // Reference model: expands one instruction into its expected per-cycle trace.
    task automatic add(input logic [5:0] op, input logic mr, input logic z, input logic [3:0] st,
                       input logic rw, input logic pcwe, input logic ill);
        cyc_t c;
        c.op = op; c.mr = mr; c.z = z; c.st = st;
        c.rw = rw; c.pcwe = pcwe; c.ill = ill; c.err = err_pend;
        err_pend = 1'b0;
        q.push_back(c);
    endtask

    task automatic mem_phase(input logic [5:0] op, input logic [3:0] st, input int w, output logic ab);
        ab = 1'b0;
        for (int i = 0; i < w && i < TMO; i++) add(op, 1'b0, 1'b0, st, 1'b0, 1'b0, 1'b0);
        if (w >= TMO) begin
            ab = 1'b1;
            err_pend = 1'b1;
        end else begin
            add(op, 1'b1, 1'b0, st, 1'b0, (st == 4'd0), 1'b0);
        end
    endtask

    task automatic gen(input logic [5:0] op, input int wf, input int wm, input logic z);
        logic ab;
        logic r;
        mem_phase(op, 4'd0, wf, ab);
        if (ab) return;
        r = 1'($urandom);
        case (op)
            6'h23: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
                mem_phase(op, 4'd3, wm, ab);
                if (!ab) add(op, r, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
            end
            6'h2B: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
                mem_phase(op, 4'd5, wm, ab);
            end
            6'h00: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
            end
            6'h08: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0);
            end
            6'h04: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, z, 4'd8, 1'b0, z, 1'b0);
            end
            6'h02: begin
                add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
                add(op, r, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
            end
            default: add(op, r, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        endcase
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(13, 17));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [8];
        clk = 1'b0;
        reset = 1'b0;
        n_total = 0;
        n_pass = 0;
        err_pend = 1'b0;
        bus_if.opcode = 6'h00;
        bus_if.mem_ready = 1'b1;
        bus_if.zero = 1'b0;

        // Reset: enables held off while reset low, FETCH decode visible.
        adv();
        chk("rst_state", 32'(bus_if.state), 32'd0);
        chk("rst_irwrite", 32'(bus_if.IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(bus_if.PCWrite), 32'd0);
        chk("rst_pcwriteen", 32'(bus_if.PCWriteEn), 32'd0);
        chk("rst_memwrite", 32'(bus_if.MemWrite), 32'd0);
        chk("rst_regwrite", 32'(bus_if.RegWrite), 32'd0);
        chk("rst_mem_err", 32'(bus_if.mem_err), 32'd0);
        chk("rst_alusrcb", 32'(bus_if.ALUSrcB), 32'd1);
        reset = 1'b1;
        #1;
        chk("rel_irwrite", 32'(bus_if.IRWrite), 32'd1);
        adv();
        chk("rel_next_state", 32'(bus_if.state), 32'd1);

        // Table-driven single-cycle vectors through every instruction class.
        addv(6'h23, 1, 0, 4'd0, C_FETCH_R); addv(6'h23, 1, 0, 4'd1, C_DEC);
        addv(6'h23, 1, 0, 4'd2, C_MEMADR);  addv(6'h23, 1, 0, 4'd3, C_MEMREAD);
        addv(6'h23, 1, 0, 4'd4, C_MEMWB);
        addv(6'h00, 1, 0, 4'd0, C_FETCH_R); addv(6'h00, 1, 0, 4'd1, C_DEC);
        addv(6'h00, 1, 0, 4'd6, C_EXEC);    addv(6'h00, 1, 0, 4'd7, C_ALUWB);
        addv(6'h08, 1, 0, 4'd0, C_FETCH_R); addv(6'h08, 1, 0, 4'd1, C_DEC);
        addv(6'h08, 1, 0, 4'd9, C_ADDIEX);  addv(6'h08, 1, 0, 4'd10, C_ADDIWB);
        addv(6'h04, 1, 0, 4'd0, C_FETCH_R); addv(6'h04, 1, 0, 4'd1, C_DEC);
        addv(6'h04, 1, 1, 4'd8, C_BR1);
        addv(6'h04, 1, 0, 4'd0, C_FETCH_R); addv(6'h04, 1, 0, 4'd1, C_DEC);
        addv(6'h04, 1, 0, 4'd8, C_BR0);
        addv(6'h02, 1, 0, 4'd0, C_FETCH_R); addv(6'h02, 1, 0, 4'd1, C_DEC);
        addv(6'h02, 1, 0, 4'd11, C_JUMP);
        addv(6'h3F, 1, 0, 4'd0, C_FETCH_R); addv(6'h3F, 1, 0, 4'd1, C_DEC_ILL);
        addv(6'h00, 0, 0, 4'd0, C_FETCH_W); addv(6'h00, 1, 0, 4'd0, C_FETCH_R);
        addv(6'h00, 1, 0, 4'd1, C_DEC);
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].mr, tbl[i].z);
            chk($sformatf("tbl%0d_state", i), 32'(bus_if.state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
            adv();
        end

        // Reset asserted in MEMWB aborts before the register write.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(6'h23, 1'b1, 1'b0);
            adv();
        end
        reset = 1'b0;
        #1;
        chk("midrst_state", 32'(bus_if.state), 32'd0);
        chk("midrst_regwrite", 32'(bus_if.RegWrite), 32'd0);
        adv();
        reset = 1'b1;

        // sw with three stall cycles in MEMWRITE.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(6'h2B, 1'b1, 1'b0);
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            drive(6'h2B, (k == 3), 1'b0);
            chk("sw_state", 32'(bus_if.state), 32'd5);
            chk("sw_memwrite", 32'(bus_if.MemWrite), 32'd1);
            chk("sw_mem_err", 32'(bus_if.mem_err), 32'd0);
            adv();
        end
        drive(6'h2B, 1'b1, 1'b0);
        chk("sw_exit_state", 32'(bus_if.state), 32'd0);
        chk("sw_exit_mem_err", 32'(bus_if.mem_err), 32'd0);

        // FETCH timeout: 16 waiting cycles, then a single mem_err pulse.
        do_reset();
        for (int k = 0; k < TMO; k++) begin
            drive(6'h00, 1'b0, 1'b0);
            chk("tmo_f_state", 32'(bus_if.state), 32'd0);
            chk("tmo_f_irwrite", 32'(bus_if.IRWrite), 32'd0);
            chk("tmo_f_mem_err_early", 32'(bus_if.mem_err), 32'd0);
            adv();
        end
        drive(6'h00, 1'b0, 1'b0);
        chk("tmo_f_mem_err", 32'(bus_if.mem_err), 32'd1);
        chk("tmo_f_state_after", 32'(bus_if.state), 32'd0);
        adv();
        drive(6'h00, 1'b0, 1'b0);
        chk("tmo_f_mem_err_once", 32'(bus_if.mem_err), 32'd0);

        // MEMREAD: ready arriving in the last allowed cycle completes normally.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(6'h23, 1'b1, 1'b0);
            adv();
        end
        for (int k = 0; k < TMO; k++) begin
            drive(6'h23, (k == TMO - 1), 1'b0);
            chk("edge_mr_state", 32'(bus_if.state), 32'd3);
            adv();
        end
        drive(6'h23, 1'b1, 1'b0);
        chk("edge_mr_wb_state", 32'(bus_if.state), 32'd4);
        chk("edge_mr_regwrite", 32'(bus_if.RegWrite), 32'd1);
        chk("edge_mr_mem_err", 32'(bus_if.mem_err), 32'd0);

        // MEMREAD timeout: abort to FETCH, no register write.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(6'h23, 1'b1, 1'b0);
            adv();
        end
        for (int k = 0; k < TMO; k++) begin
            drive(6'h23, 1'b0, 1'b0);
            adv();
        end
        drive(6'h23, 1'b0, 1'b0);
        chk("tmo_mr_state", 32'(bus_if.state), 32'd0);
        chk("tmo_mr_mem_err", 32'(bus_if.mem_err), 32'd1);
        chk("tmo_mr_regwrite", 32'(bus_if.RegWrite), 32'd0);

        // Randomized instruction stream against the trace model.
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
        do_reset();
        err_pend = 1'b0;
        for (int n = 0; n < 60; n++)
            gen(ops[$urandom_range(0, 7)], pick_wait(), pick_wait(), 1'($urandom));
        foreach (q[i]) begin
            drive(q[i].op, q[i].mr, q[i].z);
            chk("rnd_state", 32'(bus_if.state), 32'(q[i].st));
            chk("rnd_regwrite", 32'(bus_if.RegWrite), 32'(q[i].rw));
            chk("rnd_pcwriteen", 32'(bus_if.PCWriteEn), 32'(q[i].pcwe));
            chk("rnd_mem_err", 32'(bus_if.mem_err), 32'(q[i].err));
            chk("rnd_illegal", 32'(bus_if.illegal_op), 32'(q[i].ill));
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
